// File: rtl/compressor12_pkg.sv
// Shared widths and types for the 12-input ones-counter pipeline.
//   N_IN  : number of single-bit inputs
//   CNT_W : width of the ones count (0..12 fits in 4 bits)
//   GRP   : bits per full-adder group
//   N_GRP : number of full-adder groups in stage 1
package compressor12_pkg;

  localparam int unsigned N_IN  = 12;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GRP   = 3;
  localparam int unsigned N_GRP = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder used as a 3:2 compressor in stage 1.
//   a, b, cin : input bits
//   s         : sum bit (weight 1)
//   co        : carry bit (weight 2)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic w_ab;

  assign w_ab = a ^ b;
  assign s    = w_ab ^ cin;
  assign co   = (a & b) | (cin & w_ab);

endmodule

// File: rtl/compressor12_pipe.sv
// Two-stage pipelined 12-input ones counter (12:4 compressor).
// Stage 1 reduces each 3-bit group with a full adder into sum/carry
// registers; stage 2 adds the partial results into a 4-bit count.
// Valid/ready on both sides, one vector per cycle when not stalled.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   i0..i11              : input bits (i0 is the LSB position)
//   in_valid / in_ready  : input handshake (in_ready is combinational)
//   count / out_valid    : registered result and its valid
//   out_ready            : downstream accepts count this cycle
//   acc_clr / acc        : running-sum clear and value, present only
//                          when COMPRESSOR12_ACC_EN is defined
//                          (width set by parameter ACC_W)
module compressor12_pipe
  import compressor12_pkg::*;
`ifdef COMPRESSOR12_ACC_EN
#(
  parameter int unsigned ACC_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  input  logic             i3,
  input  logic             i4,
  input  logic             i5,
  input  logic             i6,
  input  logic             i7,
  input  logic             i8,
  input  logic             i9,
  input  logic             i10,
  input  logic             i11,
  input  logic             in_valid,
  output logic             in_ready,
  output cnt_t             count,
  output logic             out_valid,
  input  logic             out_ready
`ifdef COMPRESSOR12_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc
`endif
);

  logic [N_IN-1:0]  w_in;
  logic [N_GRP-1:0] w_fa_s;
  logic [N_GRP-1:0] w_fa_c;
  logic             w_adv1;
  logic             w_adv2;
  logic             w_in_xfer;
  cnt_t             w_count_next;

  logic             r_s1_valid;
  logic [N_GRP-1:0] r_s;
  logic [N_GRP-1:0] r_c;
  logic             r_out_valid;
  cnt_t             r_count;

  assign w_in = {i11, i10, i9, i8, i7, i6, i5, i4, i3, i2, i1, i0};

  // Pipeline advance: a stage may load when it is empty or its
  // successor is moving this cycle. No skid buffer, so in_ready
  // follows out_ready combinationally.
  assign w_adv2    = !r_out_valid || out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign in_ready  = w_adv1;
  assign w_in_xfer = in_valid && w_adv1;

  // Stage 1 carry-save layer: one full adder per 3-bit group.
  for (genvar g = 0; g < int'(N_GRP); g++) begin : g_fa
    fa_cell u_fa (
      .a   (w_in[g*GRP]),
      .b   (w_in[g*GRP+1]),
      .cin (w_in[g*GRP+2]),
      .s   (w_fa_s[g]),
      .co  (w_fa_c[g])
    );
  end

  // Stage 1 registers; data loads only on a transfer so idle-cycle
  // garbage on i* never reaches the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s        <= '0;
      r_c        <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_xfer) begin
        r_s <= w_fa_s;
        r_c <= w_fa_c;
      end
    end
  end

  // Stage 2 final add: sums weigh 1, carries weigh 2; max is 12.
  always_comb begin
    w_count_next = '0;
    for (int k = 0; k < int'(N_GRP); k++) begin
      w_count_next = w_count_next + CNT_W'(r_s[k]) + CNT_W'({r_c[k], 1'b0});
    end
  end

  // Stage 2 registers; count keeps its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_count <= w_count_next;
      end
    end
  end

  assign count     = r_count;
  assign out_valid = r_out_valid;

`ifdef COMPRESSOR12_ACC_EN
  logic [ACC_W-1:0] r_acc;

  // Running sum of consumed counts, wrapping; clear wins over add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (r_out_valid && out_ready) begin
      r_acc <= r_acc + ACC_W'(r_count);
    end
  end

  assign acc = r_acc;
`else
  // Accumulator not built.
`endif

endmodule

// File: doc/compressor12_pipe.md
Name: compressor12_pipe

Overview:
- Pipelined 12-input ones-counter (12:4 compressor); consumes the twelve single-bit wires produced by the 12-wire extractor stage directly upstream.
- Input bits enter a carry-save full-adder layer in stage 1; the final add happens in stage 2.
- Valid/ready handshake on both sides; full throughput of one vector per cycle when not back-pressured.

Parameters:
- ACC_W, 16, accumulator width; used only when COMPRESSOR12_ACC_EN is defined; legal range 5..32.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- i0..i11  input  1 each  data bits from the upstream extractor; i0 is the LSB position (weight is irrelevant to the count)
- in_valid  input  1  i0..i11 hold a vector
- in_ready  output  1  block accepts the vector this cycle
- count  output  4  number of ones in the accepted vector, 0..12
- out_valid  output  1  count is valid
- out_ready  input  1  downstream consumes count this cycle
- acc_clr  input  1  synchronous accumulator clear (exists only with COMPRESSOR12_ACC_EN)
- acc  output  ACC_W  running sum of counts (exists only with COMPRESSOR12_ACC_EN)

Behaviour:
- Reset (rst_n=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, count=0, all stage registers=0, acc=0. in_ready=1 one cycle after rst_n deasserts. Any in-flight vectors are discarded.
- Transfer rule: a transfer occurs when valid&&ready on the same rising edge.
- Stage 1:
  - Bits split into groups {i0,i1,i2}, {i3,i4,i5}, {i6,i7,i8}, {i9,i10,i11}.
  - Each group goes through one full adder and registers sum s[k] and carry c[k], k=0..3.
  - Registers load and s1_valid is set on input transfer.
- Stage 2:
  - count_next = (s0+s1+s2+s3) + 2*(c0+c1+c2+c3), computed at 4 bits; no overflow is possible since the maximum is 12.
  - Result is registered into count/out_valid.
- Latency: 2 cycles from input transfer to out_valid with no stalls.
- Advance logic:
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational from out_ready; no skid buffer)
- Stall behaviour: while out_valid=1 and out_ready=0, count and out_valid hold and stage 1 holds. in_ready drops only when both stages are full.
- Bubbles: when s1_valid=0, a stage-2 advance clears out_valid. count keeps its last value when out_valid=0 (not re-zeroed).
- Simultaneous events: input transfer, stage-1 to stage-2 move and output consume in the same cycle is legal and sustains 1 vector/cycle.
- Data sampling: data inputs are sampled only on transfer; X on i* while in_valid=0 must not propagate to count.

Optional Feature:
- Macro: COMPRESSOR12_ACC_EN.
- Defined:
  - Adds acc_clr and acc.
  - On each output transfer (out_valid&&out_ready), acc <= acc + count, modulo 2^ACC_W (wraps, no saturation).
  - acc_clr=1 loads 0 and has priority over a same-cycle add.
  - Reset value is 0.
- Undefined: acc_clr and acc do not exist; no accumulator logic.

Decomposition:
- Package compressor12_pkg:
  - N_IN=12
  - CNT_W=4
  - GRP=3
  - N_GRP=4
  - typedef cnt_t (logic [CNT_W-1:0])
- Sub-module fa_cell: combinational 1-bit full adder (a, b, cin -> s, co), instantiated 4 times in stage 1. The stage-2 adder stays inline.

Test Plan:
- Reset then single vector i11..i0=12'b1010_0110_0011, in_valid for 1 cycle, out_ready=1 -> out_valid=1 exactly 2 cycles later with count=6, then out_valid=0.
- Back-to-back vectors 12'h000, 12'hFFF, 12'h001, 12'h800, 12'h5A5 with out_ready=1 -> counts 0, 12, 1, 1, 6 on consecutive cycles, in_ready stays 1.
- Hold out_ready=0 while feeding 12'hFFF, 12'h00F, 12'h0F0 -> in_ready falls after 2 accepted; count=12 holds. Raise out_ready -> 12, 4, 4 emitted in order, none lost or duplicated.
- Assert rst_n=0 mid-stream with both stages full -> out_valid=0 and count=0 immediately (asynchronously); after release, first new vector 12'h003 yields count=2 at latency 2.
- Exhaustive: all 4096 vectors with random out_ready/in_valid gaps -> every count equals a scoreboard popcount, in order.
- With COMPRESSOR12_ACC_EN, ACC_W=5: feed 12'hFFF three times -> acc=12, 24, 4 (wrap). acc_clr coincident with a 4th transfer -> acc=0.
